lagarto_store_buffer: RTL and testbench

//  Buffers stores leaving lagarto_dcache_interface (st_mem_req_* path) and drains them in

---
 rtl/lagarto_store_buffer_pkg.sv | 22 ++
 rtl/lagarto_store_buffer.sv | 192 +++++++++++++++++++
 tb/tb_lagarto_store_buffer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lagarto_store_buffer_pkg.sv
// Shared types and widths for the Lagarto store buffer.
// The entry layout follows the L1 dcache index/tag widths used by the store port.
package lagarto_store_buffer_pkg;

  localparam int DCACHE_INDEX_WIDTH = 12;
  localparam int DCACHE_TAG_WIDTH   = 28;

  typedef struct packed {
    logic                          valid;
    logic [DCACHE_INDEX_WIDTH-1:0] index;
    logic [DCACHE_TAG_WIDTH-1:0]   tag;
    logic [63:0]                   wdata;
    logic [7:0]                    be;
    logic [1:0]                    size;
  } stb_entry_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_TAG  = 1'b1
  } stb_state_t;

endpackage

// File: rtl/lagarto_store_buffer.sv
// In-order store buffer between the exe-stage store path and the dcache
// store port. Drains with the two-phase protocol: index phase held until
// req_gnt_i, then a single-cycle tag strobe that retires the head entry.
// Load checks flag any pending store whose bytes overlap the load.
// Optional feature macro: LAGARTO_STB_FWD_EN enables store-to-load forwarding
// from the youngest overlapping entry when it covers every loaded byte.
module lagarto_store_buffer
  import lagarto_store_buffer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int INDEX_W = DCACHE_INDEX_WIDTH,
  parameter int TAG_W   = DCACHE_TAG_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       st_valid_i,
  input  logic [INDEX_W-1:0]         st_index_i,
  input  logic [TAG_W-1:0]           st_tag_i,
  input  logic [63:0]                st_wdata_i,
  input  logic [7:0]                 st_be_i,
  input  logic [1:0]                 st_size_i,
  output logic                       st_ready_o,
  output logic                       req_valid_o,
  output logic                       req_we_o,
  output logic                       req_kill_o,
  output logic [INDEX_W-1:0]         req_addr_index_o,
  output logic [63:0]                req_wdata_o,
  output logic [7:0]                 req_be_o,
  output logic [1:0]                 req_size_o,
  input  logic                       req_gnt_i,
  output logic [TAG_W-1:0]           req_addr_tag_o,
  output logic                       req_tag_valid_o,
  input  logic                       ld_chk_valid_i,
  input  logic [INDEX_W-1:0]         ld_chk_index_i,
  input  logic [TAG_W-1:0]           ld_chk_tag_i,
  input  logic [7:0]                 ld_chk_be_i,
  output logic                       ld_conflict_o,
  output logic                       ld_fwd_hit_o,
  output logic [63:0]                ld_fwd_data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  stb_entry_t       entries_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  stb_state_t       state_r;
  stb_state_t       state_nxt_s;
  logic             push_s;
  logic             pop_s;
  logic             idx_req_s;
  logic [DEPTH-1:0] match_s;

  // Readiness depends on occupancy only, so a full buffer never accepts a
  // push even when the head retires in the same cycle.
  assign st_ready_o = (count_r < CNT_W'(DEPTH));
  assign push_s     = st_valid_i & st_ready_o;
  assign pop_s      = (state_r == S_TAG);

  assign req_we_o         = 1'b1;
  assign req_kill_o       = 1'b0;
  assign req_addr_index_o = entries_r[rd_ptr_r].index;
  assign req_wdata_o      = entries_r[rd_ptr_r].wdata;
  assign req_be_o         = entries_r[rd_ptr_r].be;
  assign req_size_o       = entries_r[rd_ptr_r].size;
  assign req_addr_tag_o   = entries_r[rd_ptr_r].tag;
  assign empty_o          = (count_r == CNT_W'(0));
  assign count_o          = count_r;

  // Drain FSM: hold the index phase until granted, then one tag-phase cycle.
  always_comb begin
    state_nxt_s     = state_r;
    idx_req_s       = 1'b0;
    req_tag_valid_o = 1'b0;
    case (state_r)
      S_IDLE: begin
        idx_req_s = (count_r != CNT_W'(0));
        if (idx_req_s && req_gnt_i) begin
          state_nxt_s = S_TAG;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_TAG: begin
        req_tag_valid_o = 1'b1;
        state_nxt_s     = S_IDLE;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
    req_valid_o = idx_req_s;
  end

  // Drain state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CNT_W'(1);
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CNT_W'(1);
      end
    end
  end

  // Entry storage: a push never targets the head being retired, because a
  // retire with wr_ptr==rd_ptr implies a full buffer that refuses pushes.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
    end else begin
      if (pop_s) begin
        entries_r[rd_ptr_r].valid <= 1'b0;
      end
      if (push_s) begin
        entries_r[wr_ptr_r] <= '{valid: 1'b1, index: st_index_i, tag: st_tag_i,
                                 wdata: st_wdata_i, be: st_be_i, size: st_size_i};
      end
    end
  end

  // Per-entry overlap: same tag, same 8-byte word, at least one common byte.
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    assign match_s[g] = entries_r[g].valid
                      && (entries_r[g].tag == ld_chk_tag_i)
                      && (entries_r[g].index[INDEX_W-1:3] == ld_chk_index_i[INDEX_W-1:3])
                      && ((entries_r[g].be & ld_chk_be_i) != 8'h00);
  end

`ifdef LAGARTO_STB_FWD_EN
  logic [PTR_W-1:0] cand_s;
  logic [PTR_W-1:0] sel_s;
  logic             found_s;
  logic             cover_s;

  // Youngest-match select: scan backwards from the slot just below wr_ptr.
  always_comb begin
    cand_s  = '0;
    sel_s   = '0;
    found_s = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      cand_s = wr_ptr_r - PTR_W'(k);
      if (!found_s && match_s[cand_s]) begin
        found_s = 1'b1;
        sel_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    cover_s = ((entries_r[sel_s].be & ld_chk_be_i) == ld_chk_be_i);
    if (ld_chk_valid_i && found_s && cover_s) begin
      ld_fwd_hit_o  = 1'b1;
      ld_fwd_data_o = entries_r[sel_s].wdata;
      ld_conflict_o = 1'b0;
    end else begin
      ld_fwd_hit_o  = 1'b0;
      ld_fwd_data_o = 64'h0;
      ld_conflict_o = ld_chk_valid_i & found_s;
    end
  end
`else
  assign ld_conflict_o = ld_chk_valid_i & (|match_s);
  assign ld_fwd_hit_o  = 1'b0;
  assign ld_fwd_data_o = 64'h0;
`endif

endmodule

// File: tb/tb_lagarto_store_buffer.sv
// Self-checking bench for lagarto_store_buffer. A queue-based model of the
// buffer and its drain phase predicts every output on each falling edge;
// directed sequences add hand-computed expectations. Honours LAGARTO_STB_FWD_EN.
module tb_lagarto_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        st_valid;
  logic [11:0] st_index;
  logic [27:0] st_tag;
  logic [63:0] st_wdata;
  logic [7:0]  st_be;
  logic [1:0]  st_size;
  logic        st_ready;
  logic        req_valid, req_we, req_kill, req_gnt, req_tag_valid;
  logic [11:0] req_addr_index;
  logic [63:0] req_wdata;
  logic [7:0]  req_be;
  logic [1:0]  req_size;
  logic [27:0] req_addr_tag;
  logic        ld_chk_valid;
  logic [11:0] ld_chk_index;
  logic [27:0] ld_chk_tag;
  logic [7:0]  ld_chk_be;
  logic        ld_conflict, ld_fwd_hit, empty;
  logic [63:0] ld_fwd_data;
  logic [2:0]  count;

  int vectors = 0;
  int miscompares = 0;

  lagarto_store_buffer #(.DEPTH(DEPTH), .INDEX_W(12), .TAG_W(28)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .st_valid_i(st_valid), .st_index_i(st_index), .st_tag_i(st_tag),
    .st_wdata_i(st_wdata), .st_be_i(st_be), .st_size_i(st_size), .st_ready_o(st_ready),
    .req_valid_o(req_valid), .req_we_o(req_we), .req_kill_o(req_kill),
    .req_addr_index_o(req_addr_index), .req_wdata_o(req_wdata), .req_be_o(req_be),
    .req_size_o(req_size), .req_gnt_i(req_gnt), .req_addr_tag_o(req_addr_tag),
    .req_tag_valid_o(req_tag_valid),
    .ld_chk_valid_i(ld_chk_valid), .ld_chk_index_i(ld_chk_index), .ld_chk_tag_i(ld_chk_tag),
    .ld_chk_be_i(ld_chk_be), .ld_conflict_o(ld_conflict), .ld_fwd_hit_o(ld_fwd_hit),
    .ld_fwd_data_o(ld_fwd_data), .empty_o(empty), .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [11:0] index;
    logic [27:0] tag;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [1:0]  size;
  } ent_t;

  ent_t q[$];
  bit   in_tag;

  // Model state advance: retire after the tag phase, grant starts tag phase, append pushes.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q.delete();
      in_tag = 1'b0;
    end else begin
      bit room;
      ent_t e;
      room = (q.size() < DEPTH);
      if (in_tag) begin
        void'(q.pop_front());
        in_tag = 1'b0;
      end else if (q.size() > 0 && req_gnt === 1'b1) begin
        in_tag = 1'b1;
      end
      if (st_valid && room) begin
        e.index = st_index; e.tag = st_tag; e.wdata = st_wdata;
        e.be = st_be; e.size = st_size;
        q.push_back(e);
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    bit        any, hit, found;
    logic [63:0] fdata;
    any = 1'b0; hit = 1'b0; found = 1'b0; fdata = 64'h0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].tag == ld_chk_tag && q[i].index[11:3] == ld_chk_index[11:3]
          && (q[i].be & ld_chk_be) != 8'h00) begin
        any = 1'b1;
        if (!found) begin
          found = 1'b1;
          if ((q[i].be & ld_chk_be) == ld_chk_be) begin
            hit = 1'b1;
            fdata = q[i].wdata;
          end
        end
      end
    end
    chk("m_st_ready", st_ready, q.size() < DEPTH);
    chk("m_count", count, q.size());
    chk("m_empty", empty, q.size() == 0);
    chk("m_req_valid", req_valid, !in_tag && q.size() > 0);
    chk("m_tag_valid", req_tag_valid, in_tag);
    chk("m_we_kill", {req_we, req_kill}, 2'b10);
    if (q.size() > 0) begin
      chk("m_head_index", req_addr_index, q[0].index);
      chk("m_head_wdata", req_wdata, q[0].wdata);
      chk("m_head_be_size", {req_be, req_size}, {q[0].be, q[0].size});
      chk("m_head_tag", req_addr_tag, q[0].tag);
    end
`ifdef LAGARTO_STB_FWD_EN
    chk("m_conflict", ld_conflict, ld_chk_valid && found && !hit);
    chk("m_fwd_hit", ld_fwd_hit, ld_chk_valid && hit);
    chk("m_fwd_data", ld_fwd_data, (ld_chk_valid && hit) ? fdata : 64'h0);
`else
    chk("m_conflict", ld_conflict, ld_chk_valid && any);
    chk("m_fwd_hit", ld_fwd_hit, 1'b0);
    chk("m_fwd_data", ld_fwd_data, 64'h0);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_st(input logic v, input logic [11:0] idx, input logic [27:0] tg,
                        input logic [63:0] d, input logic [7:0] be, input logic [1:0] sz);
    st_valid = v; st_index = idx; st_tag = tg; st_wdata = d; st_be = be; st_size = sz;
  endtask

  task automatic set_ld(input logic v, input logic [11:0] idx, input logic [27:0] tg,
                        input logic [7:0] be);
    ld_chk_valid = v; ld_chk_index = idx; ld_chk_tag = tg; ld_chk_be = be;
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    st_valid = 1'b0;
    req_gnt = 1'b1;
    while (count != 3'd0 && cyc < 100) begin
      tick();
      cyc++;
    end
    req_gnt = 1'b0;
    #1;
    chk(name, empty, 1'b1);
  endtask

  initial begin
    rstn = 1'b0;
    req_gnt = 1'b0;
    set_st(1'b0, 12'h000, 28'h0, 64'h0, 8'h00, 2'd0);
    set_ld(1'b0, 12'h000, 28'h0, 8'h00);
    repeat (2) tick();
    chk("rst_outputs", {st_ready, empty, count, req_valid, req_tag_valid, ld_conflict, ld_fwd_hit},
        {1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    rstn = 1'b1;
    tick();

    // 1: single SD, granted on the first request cycle.
    set_st(1'b1, 12'h048, 28'h1A, 64'h0102_0304_0506_0708, 8'hFF, 2'd3);
    tick();
    st_valid = 1'b0;
    req_gnt = 1'b1;
    #1;
    chk("t1_req_valid", {req_valid, req_addr_index}, {1'b1, 12'h048});
    tick();
    req_gnt = 1'b0;
    #1;
    chk("t1_tag_phase", {req_tag_valid, req_valid, req_addr_tag}, {1'b1, 1'b0, 28'h1A});
    tick();
    chk("t1_empty", {empty, count}, {1'b1, 3'd0});

    // 2: fill with no grant, overflow push ignored, then drain 10 stores with wrap.
    for (int i = 0; i < 4; i++) begin
      set_st(1'b1, 12'(8 * i), 28'(16'h100 + i), {32'hA5A5_0000, 32'(i)}, 8'hFF, 2'd3);
      tick();
    end
    st_valid = 1'b0;
    #1;
    chk("t2_full", {st_ready, count}, {1'b0, 3'd4});
    set_st(1'b1, 12'h0F8, 28'h1FF, 64'hBAD, 8'hFF, 2'd3);
    tick();
    st_valid = 1'b0;
    #1;
    chk("t2_overflow_ignored", count, 3'd4);
    begin
      int n, cyc;
      n = 4; cyc = 0;
      req_gnt = 1'b1;
      while ((n < 10 || count != 3'd0) && cyc < 200) begin
        set_st(n < 10, 12'(8 * n), 28'(16'h100 + n), {32'hA5A5_0000, 32'(n)}, 8'hFF, 2'd3);
        #1;
        if (st_valid && st_ready) n++;
        tick();
        cyc++;
      end
      st_valid = 1'b0;
      req_gnt = 1'b0;
      #1;
      chk("t2_drained", {empty, 4'(n)}, {1'b1, 4'd10});
    end

    // 3: full, grant plus push in the same cycle -> push rejected, count 3 after pop.
    for (int i = 0; i < 4; i++) begin
      set_st(1'b1, 12'(8 * i), 28'h33, 64'(i), 8'h0F, 2'd2);
      tick();
    end
    set_st(1'b1, 12'h100, 28'h44, 64'hFFFF, 8'hFF, 2'd3);
    req_gnt = 1'b1;
    tick();
    req_gnt = 1'b0;
    tick();
    st_valid = 1'b0;
    #1;
    chk("t3_count_after_pop", {count, st_ready}, {3'd3, 1'b1});
    drain("t3_drained");

    // 4: byte-lane overlap on a pending SW.
    set_st(1'b1, 12'h040, 28'h05, 64'h0000_0000_CAFE_F00D, 8'h0F, 2'd2);
    tick();
    st_valid = 1'b0;
    set_ld(1'b1, 12'h044, 28'h05, 8'hF0);
    #1;
    chk("t4_disjoint", {ld_conflict, ld_fwd_hit}, 2'b00);
    set_ld(1'b1, 12'h040, 28'h05, 8'h01);
    #1;
`ifdef LAGARTO_STB_FWD_EN
    chk("t4_overlap", {ld_conflict, ld_fwd_hit, ld_fwd_data}, {2'b01, 64'h0000_0000_CAFE_F00D});
`else
    chk("t4_overlap", {ld_conflict, ld_fwd_hit}, 2'b10);
`endif
    set_ld(1'b1, 12'h040, 28'h06, 8'h01);
    #1;
    chk("t4_other_tag", ld_conflict, 1'b0);
    set_ld(1'b0, 12'h000, 28'h0, 8'h00);
    drain("t4_drained");

    // 5: full-cover forwarding and youngest-wins.
    set_st(1'b1, 12'h080, 28'h07, 64'hDEAD_BEEF_0123_4567, 8'hFF, 2'd3);
    tick();
    st_valid = 1'b0;
    set_ld(1'b1, 12'h080, 28'h07, 8'hFF);
    #1;
`ifdef LAGARTO_STB_FWD_EN
    chk("t5_fwd", {ld_fwd_hit, ld_conflict, ld_fwd_data}, {2'b10, 64'hDEAD_BEEF_0123_4567});
`else
    chk("t5_fwd", {ld_fwd_hit, ld_conflict, ld_fwd_data}, {2'b01, 64'h0});
`endif
    set_st(1'b1, 12'h080, 28'h07, 64'h1234_5678_9ABC_DEF0, 8'hFF, 2'd3);
    tick();
    st_valid = 1'b0;
    #1;
`ifdef LAGARTO_STB_FWD_EN
    chk("t5_youngest", {ld_fwd_hit, ld_fwd_data}, {1'b1, 64'h1234_5678_9ABC_DEF0});
`else
    chk("t5_youngest", {ld_fwd_hit, ld_conflict}, 2'b01);
`endif
    set_ld(1'b0, 12'h000, 28'h0, 8'h00);
    drain("t5_drained");

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      set_st(($urandom_range(0, 99) < 55), 12'($urandom_range(0, 3) * 8 + $urandom_range(0, 7)),
             28'($urandom_range(1, 2)), {$urandom, $urandom}, 8'($urandom_range(1, 255)),
             2'($urandom_range(0, 3)));
      req_gnt = ($urandom_range(0, 99) < 45);
      set_ld($urandom_range(0, 1) == 1, 12'($urandom_range(0, 3) * 8 + $urandom_range(0, 7)),
             28'($urandom_range(1, 2)), 8'($urandom_range(0, 255)));
      tick();
    end
    set_ld(1'b0, 12'h000, 28'h0, 8'h00);
    drain("rand_drained");

    // 6: asynchronous reset during the tag phase with three stores pending.
    for (int i = 0; i < 3; i++) begin
      set_st(1'b1, 12'h200, 28'h99, 64'(i + 1), 8'hFF, 2'd3);
      tick();
    end
    st_valid = 1'b0;
    req_gnt = 1'b1;
    tick();
    req_gnt = 1'b0;
    set_ld(1'b1, 12'h200, 28'h99, 8'hFF);
    #1;
    chk("t6_in_tag", {req_tag_valid, count}, {1'b1, 3'd3});
    rstn = 1'b0;
    #1;
    chk("t6_reset_now", {req_tag_valid, req_valid, empty, count, st_ready, ld_conflict, ld_fwd_hit, ld_fwd_data},
        {1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 64'h0});
    tick();
    rstn = 1'b1;
    set_ld(1'b0, 12'h000, 28'h0, 8'h00);
    repeat (2) tick();
    chk("t6_after_reset", {empty, req_valid}, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
